// File: rtl/mole_round_if.sv
// Control inputs and score/display outputs of the whack-a-mole round controller.
// The controller takes the slave modport, the driving environment the master modport.
interface mole_round_if #(
    parameter int unsigned N_HOLES = 10,
    parameter int unsigned CNT_W   = 6
);
    logic               tick;
    logic               start;
    logic [CNT_W-1:0]   round_target;
    logic [N_HOLES-1:0] switch;
    logic [N_HOLES-1:0] mole;
    logic [CNT_W-1:0]   hits;
    logic [CNT_W-1:0]   misses;
    logic [CNT_W-1:0]   rounds_done;
    logic [2:0]         state;
    logic               game_over;
    logic [1:0]         grade;

    modport master (
        output tick, start, round_target, switch,
        input  mole, hits, misses, rounds_done, state, game_over, grade
    );

    modport slave (
        input  tick, start, round_target, switch,
        output mole, hits, misses, rounds_done, state, game_over, grade
    );
endinterface

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: LFSR-picked hole per round, tick-timed lit window,
// hit/miss scoring and a miss-based grade once the programmed round count is reached.
module mole_round_ctrl #(
    parameter int unsigned N_HOLES   = 10,
    parameter int unsigned CNT_W     = 6,
    parameter int unsigned UP_TICKS  = 4,
    parameter int unsigned GAP_TICKS = 1,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input logic         clk,
    input logic         rst_n,
    mole_round_if.slave bus
);
    localparam int unsigned IDX_W = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;
    localparam int unsigned TCK_W = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSpawn = 3'd1,
        StUp    = 3'd2,
        StGap   = 3'd3,
        StOver  = 3'd4
    } state_e;

    state_e             state_q;
    logic [7:0]         lfsr_q;
    logic [CNT_W-1:0]   target_q, hits_q, misses_q, rounds_q;
    logic [N_HOLES-1:0] mole_q;
    logic [IDX_W-1:0]   prev_idx_q;
    logic [TCK_W-1:0]   tick_cnt_q;
    logic               armed_q, game_over_q;

    logic [N_HOLES-1:0] sw_hot;
    logic [31:0]        raw_idx;
    logic [IDX_W-1:0]   spawn_idx;
    logic [CNT_W-1:0]   rounds_inc;
    logic [31:0]        miss_ext;
    logic               start_ok, lfsr_fb, up_hit, up_wrong, up_timeout, round_end;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        // Several switches at once count as no input at all.
        sw_hot = '0;
        if (bus.switch != '0 && (bus.switch & (bus.switch - N_HOLES'(1))) == '0) begin
            sw_hot = bus.switch;
        end

        raw_idx = 32'(lfsr_q) % N_HOLES;
        if (raw_idx == 32'(prev_idx_q)) begin
            spawn_idx = IDX_W'((raw_idx + 32'd1) % N_HOLES);
        end else begin
            spawn_idx = IDX_W'(raw_idx);
        end

        lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        rounds_inc = rounds_q + CNT_W'(1);
        start_ok   = bus.start && (bus.round_target != '0);

        // armed_q is the value entering the cycle: a held-over switch cannot score.
        up_hit     = armed_q && (sw_hot != '0) && (sw_hot == mole_q);
        up_wrong   = armed_q && (sw_hot != '0) && (sw_hot != mole_q);
        up_timeout = !(armed_q && (sw_hot != '0)) && bus.tick &&
                     (tick_cnt_q == TCK_W'(UP_TICKS - 1));
        round_end  = up_hit || up_wrong || up_timeout;

        miss_ext = 32'(misses_q);
        if (miss_ext < 32'd5) begin
            bus.grade = 2'd0;
        end else if (miss_ext < 32'd10) begin
            bus.grade = 2'd1;
        end else if (miss_ext < 32'd15) begin
            bus.grade = 2'd2;
        end else begin
            bus.grade = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lfsr_q      <= LFSR_SEED;
            target_q    <= '0;
            hits_q      <= '0;
            misses_q    <= '0;
            rounds_q    <= '0;
            mole_q      <= '0;
            prev_idx_q  <= '0;
            tick_cnt_q  <= '0;
            armed_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_fb};
            unique case (state_q)
                StIdle, StOver: begin
                    if (start_ok) begin
                        target_q    <= bus.round_target;
                        hits_q      <= '0;
                        misses_q    <= '0;
                        rounds_q    <= '0;
                        game_over_q <= 1'b0;
                        state_q     <= StSpawn;
                    end
                end
                StSpawn: begin
                    mole_q     <= N_HOLES'(1) << spawn_idx;
                    prev_idx_q <= spawn_idx;
                    tick_cnt_q <= '0;
                    armed_q    <= 1'b0;
                    state_q    <= StUp;
                end
                StUp: begin
                    if (bus.switch == '0) begin
                        armed_q <= 1'b1;
                    end
                    if (up_hit) begin
                        hits_q <= sat_inc(hits_q);
                    end
                    if (up_wrong || up_timeout) begin
                        misses_q <= sat_inc(misses_q);
                    end
                    if (round_end) begin
                        mole_q     <= '0;
                        rounds_q   <= rounds_inc;
                        tick_cnt_q <= '0;
                        if (rounds_inc == target_q) begin
                            state_q     <= StOver;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q <= StGap;
                        end
                    end else if (bus.tick) begin
                        tick_cnt_q <= tick_cnt_q + TCK_W'(1);
                    end
                end
                StGap: begin
                    if (bus.tick) begin
                        if (tick_cnt_q == TCK_W'(GAP_TICKS - 1)) begin
                            tick_cnt_q <= '0;
                            state_q    <= StSpawn;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TCK_W'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.mole        = mole_q;
    assign bus.hits        = hits_q;
    assign bus.misses      = misses_q;
    assign bus.rounds_done = rounds_q;
    assign bus.state       = state_q;
    assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Scoreboard bench for mole_round_ctrl: a game-rule model predicts every output change
// (with its cycle), a monitor compares each change the DUT actually presents.
module tb_mole_round_ctrl;
    localparam int unsigned N    = 10;
    localparam int unsigned CW   = 6;
    localparam int          UP_T = 4;
    localparam int          GAP_T = 1;
    localparam int          MAXC = 63;
    localparam int P_IDLE = 0, P_SPAWN = 1, P_UP = 2, P_GAP = 3, P_OVER = 4;

    typedef struct packed {
        logic [N-1:0]  mole;
        logic [CW-1:0] hits;
        logic [CW-1:0] misses;
        logic [CW-1:0] rd;
        logic [2:0]    st;
        logic          go;
        logic [1:0]    gr;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mole_round_if #(.N_HOLES(N), .CNT_W(CW)) bus ();
    mole_round_if #(.N_HOLES(4), .CNT_W(CW)) bus4 ();

    mole_round_ctrl #(.N_HOLES(N), .CNT_W(CW), .UP_TICKS(UP_T), .GAP_TICKS(GAP_T),
                      .LFSR_SEED(8'hA5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    mole_round_ctrl #(.N_HOLES(4), .CNT_W(CW), .UP_TICKS(UP_T), .GAP_TICKS(GAP_T),
                      .LFSR_SEED(8'hA5)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    // Small instance just keeps timing out and restarting to exercise hole selection.
    assign bus4.tick         = 1'b1;
    assign bus4.start        = 1'b1;
    assign bus4.round_target = '1;
    assign bus4.switch       = '0;

    int checks = 0, errors = 0, cyc = 0, lit_ticks = 0, spawns4 = 0;
    exp_t sb[$];

    int m_ph, m_mole, m_hits, m_miss, m_rd, m_tgt, m_prev, m_tc, m_gc;
    bit m_armed, m_over;
    bit m_first = 1'b1;
    logic [7:0] m_lfsr;
    obs_t m_last;

    function automatic obs_t model_obs();
        obs_t o;
        o.mole   = (m_mole < 0) ? '0 : (N'(1) << m_mole);
        o.hits   = CW'(m_hits);
        o.misses = CW'(m_miss);
        o.rd     = CW'(m_rd);
        o.st     = 3'(m_ph);
        o.go     = m_over;
        o.gr     = 2'((m_miss / 5 > 3) ? 3 : m_miss / 5);
        return o;
    endfunction

    always @(posedge clk) begin
        int   hot, idx;
        bit   ended;
        obs_t o;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            m_ph = P_IDLE; m_mole = -1; m_hits = 0; m_miss = 0; m_rd = 0; m_tgt = 0;
            m_prev = 0; m_tc = 0; m_gc = 0; m_armed = 0; m_over = 0; m_lfsr = 8'hA5;
        end else begin
            hot = -1;
            if ($countones(bus.switch) == 1)
                for (int i = 0; i < N; i++) if (bus.switch[i]) hot = i;
            case (m_ph)
                P_IDLE, P_OVER:
                    if (bus.start && bus.round_target != 0) begin
                        m_tgt = int'(bus.round_target);
                        m_hits = 0; m_miss = 0; m_rd = 0; m_over = 0; m_ph = P_SPAWN;
                    end
                P_SPAWN: begin
                    idx = int'(m_lfsr) % N;
                    if (idx == m_prev) idx = (idx + 1) % N;
                    m_mole = idx; m_prev = idx; m_tc = 0; m_armed = 0; m_ph = P_UP;
                end
                P_UP: begin
                    ended = 0;
                    if (m_armed && hot >= 0) begin
                        if (hot == m_mole) m_hits = (m_hits < MAXC) ? m_hits + 1 : MAXC;
                        else m_miss = (m_miss < MAXC) ? m_miss + 1 : MAXC;
                        ended = 1;
                    end else if (bus.tick) begin
                        m_tc++;
                        if (m_tc == UP_T) begin
                            m_miss = (m_miss < MAXC) ? m_miss + 1 : MAXC;
                            ended = 1;
                        end
                    end
                    if (bus.switch == 0) m_armed = 1;
                    if (ended) begin
                        m_mole = -1; m_rd++;
                        if (m_rd == m_tgt) begin m_ph = P_OVER; m_over = 1; end
                        else begin m_ph = P_GAP; m_gc = 0; end
                    end
                end
                P_GAP:
                    if (bus.tick) begin
                        m_gc++;
                        if (m_gc == GAP_T) m_ph = P_SPAWN;
                    end
                default: m_ph = P_IDLE;
            endcase
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
        o = model_obs();
        if (m_first || o != m_last) begin
            e.cyc = cyc; e.o = o; sb.push_back(e);
        end
        m_first = 0;
        m_last = o;
    end

    obs_t mon_last;
    bit   mon_first = 1'b1;

    always @(negedge clk) begin
        obs_t d;
        exp_t e;
        d.mole = bus.mole; d.hits = bus.hits; d.misses = bus.misses; d.rd = bus.rounds_done;
        d.st = bus.state; d.go = bus.game_over; d.gr = bus.grade;
        if (mon_first || d !== mon_last) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected cyc=%0d got=%h required=no change", cyc, d);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.o !== d) begin
                    errors++;
                    $display("FAIL sb_event got=%h@%0d required=%h@%0d", d, cyc, e.o, e.cyc);
                end
            end
        end
        mon_first = 0;
        mon_last = d;
    end

    logic [3:0] prev4, last4;
    always @(negedge clk) begin
        // dut4 only sits in IDLE while held in reset, where prev_idx returns to hole 0.
        if (bus4.state == 3'd0) begin
            prev4 = 4'b0001;
        end else if (bus4.mole != 0 && last4 == 0) begin
            checks++;
            spawns4++;
            if ($countones(bus4.mole) != 1 || bus4.mole == prev4) begin
                errors++;
                $display("FAIL spawn4 got=%b required=onehot and not %b", bus4.mole, prev4);
            end
            prev4 = bus4.mole;
        end
        last4 = bus4.mole;
    end

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic step(input bit t, input bit s, input logic [N-1:0] sw);
        @(negedge clk);
        bus.tick = t; bus.start = s; bus.switch = sw;
    endtask

    task automatic start_game(input int target);
        bus.round_target = CW'(target);
        step(0, 1, '0);
        step(0, 0, '0);
    endtask

    task automatic wait_mole(input bit t, input logic [N-1:0] sw, input int budget);
        int n = 0;
        do begin
            step(t, 0, sw);
            n++;
        end while (bus.mole == 0 && n < budget);
        if (bus.mole == 0) chk("wait_mole_timeout", 0, 1);
    endtask

    function automatic logic [N-1:0] rot(input logic [N-1:0] m);
        return {m[N-2:0], m[N-1]};
    endfunction

    // policy 0: press lit hole on its 2nd visible cycle; 1: never press; 2: random switches
    task automatic play(input int policy, input int tick_mod, input int budget);
        int n = 0, since = 0, r;
        bit t;
        logic [N-1:0] sw;
        while (n < budget) begin
            @(negedge clk);
            if (bus.game_over) begin
                bus.start = 0; bus.tick = 0; bus.switch = '0;
                break;
            end
            t = ($urandom_range(tick_mod - 1) == 0);
            sw = '0;
            if (policy == 0) begin
                since = (bus.mole != 0) ? since + 1 : 0;
                if (since >= 2) sw = bus.mole;
            end else if (policy == 2) begin
                r = $urandom_range(9);
                if (r >= 9) sw = N'($urandom);
                else if (r >= 7) sw = N'(1) << $urandom_range(N - 1);
                else if (r >= 5) sw = bus.mole;
                bus.start = ($urandom_range(15) == 0);
                bus.round_target = CW'($urandom);
            end
            if (bus.mole != 0 && t) lit_ticks++;
            bus.tick = t;
            bus.switch = sw;
            n++;
        end
        if (!bus.game_over) chk("play_timeout", 0, 1);
    endtask

    logic [N-1:0] held, two, wrong;

    initial begin
        bus.tick = 0; bus.start = 0; bus.round_target = '0; bus.switch = '0;
        repeat (2) begin
            @(negedge clk);
            bus.tick = 1'($urandom); bus.start = 1'($urandom);
            bus.round_target = CW'($urandom); bus.switch = N'($urandom);
        end
        @(negedge clk);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_mole", int'(bus.mole), 0);
        chk("rst_hits", int'(bus.hits), 0);
        chk("rst_misses", int'(bus.misses), 0);
        chk("rst_rounds", int'(bus.rounds_done), 0);
        chk("rst_game_over", int'(bus.game_over), 0);
        rst_n = 1; bus.tick = 0; bus.start = 0; bus.switch = '0;

        start_game(0);
        step(0, 0, '0);
        chk("target0_idle", int'(bus.state), 0);

        start_game(3);
        play(0, 4, 2000);
        chk("perfect_hits", int'(bus.hits), 3);
        chk("perfect_misses", int'(bus.misses), 0);
        chk("perfect_rounds", int'(bus.rounds_done), 3);
        chk("perfect_state", int'(bus.state), 4);
        chk("perfect_grade", int'(bus.grade), 0);

        lit_ticks = 0;
        start_game(2);
        play(1, 2, 500);
        chk("timeout_lit_ticks", lit_ticks, 8);
        chk("timeout_misses", int'(bus.misses), 2);
        chk("timeout_grade", int'(bus.grade), 0);
        chk("timeout_game_over", int'(bus.game_over), 1);

        start_game(3);
        wait_mole(0, '0, 50);
        held = bus.mole;
        step(0, 0, held);
        step(0, 0, held);
        chk("hold_r1_hit", int'(bus.hits), 1);
        wait_mole(1, held, 50);
        repeat (8) step(0, 0, held);
        chk("hold_no_hit", int'(bus.hits), 1);
        chk("hold_no_miss", int'(bus.misses), 0);
        chk("hold_still_up", int'(bus.state), 2);
        step(0, 0, '0);
        two = bus.mole | rot(bus.mole);
        repeat (3) step(0, 0, two);
        chk("multi_ignored", int'(bus.misses), 0);
        chk("multi_still_up", int'(bus.state), 2);
        wrong = rot(bus.mole);
        step(0, 0, wrong);
        step(0, 0, '0);
        chk("wrong_miss", int'(bus.misses), 1);
        chk("wrong_rounds", int'(bus.rounds_done), 2);
        wait_mole(1, '0, 50);
        step(0, 0, bus.mole);
        step(0, 0, '0);
        chk("hold_final_hits", int'(bus.hits), 2);
        chk("hold_final_state", int'(bus.state), 4);

        start_game(1);
        wait_mole(0, '0, 50);
        repeat (3) step(1, 0, '0);
        step(1, 0, bus.mole);
        step(0, 0, '0);
        chk("hit_vs_timeout_hits", int'(bus.hits), 1);
        chk("hit_vs_timeout_misses", int'(bus.misses), 0);

        start_game(2);
        wait_mole(0, '0, 50);
        step(1, 0, '0);
        @(negedge clk);
        rst_n = 0; bus.tick = 0;
        @(negedge clk);
        chk("midrst_state", int'(bus.state), 0);
        chk("midrst_mole", int'(bus.mole), 0);
        rst_n = 1;

        start_game(63);
        play(1, 1, 1000);
        chk("sat_misses", int'(bus.misses), 63);
        chk("sat_grade", int'(bus.grade), 3);
        chk("sat_rounds", int'(bus.rounds_done), 63);

        for (int g = 0; g < 6; g++) begin
            start_game(int'($urandom_range(1, 6)));
            play(2, int'($urandom_range(1, 3)), 2000);
        end

        repeat (4) step(0, 0, '0);
        #1;
        chk("sb_drained", sb.size(), 0);
        chk("spawns4_ge_50", int'(spawns4 >= 50), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
